time_uart_tx: RTL and testbench
===============================

// Module: time_uart_tx
// PURPOSE
//  Serial time reporter: the outbound end of time setting. Sends the current BCD time
//  (data_ch from the real-time clock) as ASCII "HH:MM:SS\r\n" over a UART 8N1 line.
//  Triggered on every change of the time value or by an explicit send pulse.
//  Sits beside the real-time clock in the chasy top; drives the board TXD pin.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency, Hz
//  BAUD     115_200     line rate; DIV = (CLK_HZ + BAUD/2)/BAUD clocks per bit (434 at defaults)
// PORTS
//  clock       in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-low
//  data_time   in   24  BCD time: [23:20]=H tens .. [3:0]=S units
//  send        in   1   one-cycle request pulse (e.g. debounced button)
//  auto_en     in   1   1 = also start a frame whenever data_time changes
//  txd         out  1   UART line, idle high
//  busy        out  1   high from frame start until the last stop bit ends
//  frame_done  out  1   one-cycle pulse after the stop bit of '\n'
// BEHAVIOUR
//  - Reset: txd=1, busy=0, frame_done=0, pending=0, FSM=IDLE; data_time shadow reg <= data_time.
//  - Request = send | (auto_en & data_time != shadow); shadow updates every cycle.
//  - IDLE + request at edge N: snapshot data_time, busy=1 and txd=0 (start bit) from N+1.
//  - Request while busy: set pending flag (single-deep, extra requests merge); on frame
//    completion pending starts the next frame in the cycle after frame_done, new snapshot.
//  - Snapshot is held for the entire frame; data_time changes mid-frame do not alter it.
//  - Frame = 10 chars idx 0..9: H1 H0 ':' M1 M0 ':' S1 S0 8'h0D 8'h0A.
//  - Digit char = 8'h30 + nibble; nibble > 9 sends '?' (8'h3F). No range check on values.
//  - Char: start(0), 8 data bits LSB first, [parity], stop(1); each bit exactly DIV clocks.
//  - No idle gap between chars: next start bit follows stop bit directly.
//  - FSM: IDLE -> START -> DATA(bit 0..7) -> [PARITY] -> STOP -> (idx<9 ? START : DONE)
//    DONE: frame_done=1 one cycle, busy=0 same cycle; -> START if pending else IDLE.
//  - Baud counter counts DIV-1 down to 0; resets on every bit transition. idx wraps 9 -> 0.
//  - Simultaneous send and data_time change: one request. Request in DONE cycle -> pending.
//  - Reset mid-frame: txd high immediately (async), frame abandoned, no frame_done.
// CONFIGURATION
//  TIME_TX_PARITY_EN defined: even parity bit (XOR of 8 data bits) between bit 7 and stop;
//   char = 11 bit times. Undefined: no parity state, 10 bit times per char (8N1).
// STRUCTURE
//  - chasy_pkg: state enum tx_state_t, CHAR_COLON/CHAR_CR/CHAR_LF/CHAR_ERR, FRAME_LEN=10.
//  - Sub-module uart_tx_byte: byte serializer (baud counter, bit FSM, start/ready/done).
//    time_uart_tx holds request/pending logic, snapshot, char index and BCD->ASCII mux.
// TESTING (CLK_HZ=1000, BAUD=100 -> DIV=10)
//  - data_time=24'h123456, send pulse -> txd decodes "12:34:56\r\n", frame 1000 clocks,
//    first char '1'=8'h31: bits 0,1,0,0,0,1,1,0,0,1 each 10 clocks; one frame_done.
//  - auto_en=1, data_time 24'h235959 -> 24'h000000 -> exactly one frame "00:00:00\r\n".
//  - Three send pulses during a frame -> exactly two frames total, back-to-back.
//  - data_time=24'h1A0000 -> second char '?' (8'h3F); rest "1?:00:00\r\n".
//  - Reset low at char 4 bit 3 -> txd=1 same cycle, busy=0, no frame_done; send after
//    release -> full clean frame.
//  - TIME_TX_PARITY_EN: ':' (8'h3A, four ones) -> parity bit 0; frame 1100 clocks.

Source files
------------

// File: rtl/chasy_pkg.sv
// Shared types and character constants for the chasy time-reporting UART.
// TIME_TX_PARITY_EN adds an even-parity state to the byte serializer.
package chasy_pkg;

    localparam int unsigned FRAME_LEN  = 10;

    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_ERR   = 8'h3F;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef TIME_TX_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SEND,
        FR_DONE
    } frame_state_t;

    function automatic logic [7:0] bcd_char(input logic [3:0] nibble);
        return (nibble > 4'd9) ? CHAR_ERR : (CHAR_ZERO + {4'd0, nibble});
    endfunction

    // Character idx of the "HH:MM:SS\r\n" frame for BCD time t.
    function automatic logic [7:0] frame_char(input logic [23:0] t, input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = bcd_char(t[23:20]);
            4'd1:    c = bcd_char(t[19:16]);
            4'd2:    c = CHAR_COLON;
            4'd3:    c = bcd_char(t[15:12]);
            4'd4:    c = bcd_char(t[11:8]);
            4'd5:    c = CHAR_COLON;
            4'd6:    c = bcd_char(t[7:4]);
            4'd7:    c = bcd_char(t[3:0]);
            4'd8:    c = CHAR_CR;
            default: c = CHAR_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: start bit, 8 data bits LSB first, optional even parity
// (TIME_TX_PARITY_EN), stop bit; a start request at the end of stop chains the next byte.
module uart_tx_byte
    import chasy_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       txd_o,
    output logic       ready_o,
    output logic       done_o
);

    localparam int unsigned     CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             bit_end;
`ifdef TIME_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= TX_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef TIME_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
`ifdef TIME_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bit_end = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef TIME_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != TX_IDLE && !bit_end) begin
            cnt_d = cnt_q - 1'b1;
        end
        unique case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    state_d  = TX_START;
                    cnt_d    = CNT_MAX;
                    shift_d  = data_i;
`ifdef TIME_TX_PARITY_EN
                    parity_d = ^data_i;
`endif
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    cnt_d   = CNT_MAX;
                    bit_d   = 3'd0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d   = CNT_MAX;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef TIME_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef TIME_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end) begin
                    state_d = TX_STOP;
                    cnt_d   = CNT_MAX;
                end
            end
`endif
            TX_STOP: begin
                // Chaining here keeps characters gapless: next start bit follows the stop bit.
                if (bit_end) begin
                    if (start_i) begin
                        state_d  = TX_START;
                        cnt_d    = CNT_MAX;
                        shift_d  = data_i;
`ifdef TIME_TX_PARITY_EN
                        parity_d = ^data_i;
`endif
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        txd_o = 1'b1;
        unique case (state_q)
            TX_START:  txd_o = 1'b0;
            TX_DATA:   txd_o = shift_q[0];
`ifdef TIME_TX_PARITY_EN
            TX_PARITY: txd_o = parity_q;
`endif
            default:   txd_o = 1'b1;
        endcase
    end

    assign done_o  = (state_q == TX_STOP) && bit_end;
    assign ready_o = (state_q == TX_IDLE) || done_o;

endmodule

// File: rtl/time_uart_tx.sv
// Serial time reporter: sends BCD time as "HH:MM:SS\r\n" over UART on send or time change.
// Define TIME_TX_PARITY_EN for an even-parity bit per character.
module time_uart_tx
    import chasy_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] data_time,
    input  logic        send,
    input  logic        auto_en,
    output logic        txd,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned DIV      = (CLK_HZ + BAUD / 2) / BAUD;
    localparam logic [3:0]  LAST_IDX = 4'(FRAME_LEN - 1);

    frame_state_t frame_q, frame_d;
    logic [23:0]  snap_q, snap_d;
    logic [23:0]  shadow_q;
    logic [3:0]   idx_q, idx_d;
    logic         pending_q, pending_d;
    logic         request;
    logic         start_frame;
    logic         byte_start;
    logic [7:0]   byte_data;
    logic         byte_ready;
    logic         byte_done;

    assign request = send | (auto_en & (data_time != shadow_q));

    // Shadow follows the input even in reset so the first edge afterwards sees no change.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_q   <= FR_IDLE;
            snap_q    <= '0;
            shadow_q  <= data_time;
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            frame_q   <= frame_d;
            snap_q    <= snap_d;
            shadow_q  <= data_time;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        frame_d     = frame_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        byte_start  = 1'b0;
        start_frame = 1'b0;
        unique case (frame_q)
            FR_IDLE: start_frame = request & byte_ready;
            FR_SEND: begin
                pending_d = pending_q | request;
                if (byte_done) begin
                    if (idx_q == LAST_IDX) begin
                        frame_d = FR_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        byte_start = 1'b1;
                    end
                end
            end
            FR_DONE: begin
                frame_d     = FR_IDLE;
                pending_d   = 1'b0;
                start_frame = pending_q | request;
            end
            default: frame_d = FR_IDLE;
        endcase
        if (start_frame) begin
            frame_d    = FR_SEND;
            snap_d     = data_time;
            idx_d      = '0;
            pending_d  = 1'b0;
            byte_start = 1'b1;
        end
    end

    // Character is chosen from next-state values so a new frame's first char uses the fresh snapshot.
    assign byte_data  = frame_char(snap_d, idx_d);
    assign busy       = (frame_q == FR_SEND);
    assign frame_done = (frame_q == FR_DONE);

    uart_tx_byte #(
        .DIV(DIV)
    ) u_byte (
        .clock  (clock),
        .reset  (reset),
        .start_i(byte_start),
        .data_i (byte_data),
        .txd_o  (txd),
        .ready_o(byte_ready),
        .done_o (byte_done)
    );

endmodule

// File: tb/tb_time_uart_tx.sv
// Scoreboard bench for time_uart_tx at CLK_HZ=1000, BAUD=100 (10 clocks per bit).
// Honours TIME_TX_PARITY_EN for character length and parity checking.
module tb_time_uart_tx;

    localparam int DIV = 10;
`ifdef TIME_TX_PARITY_EN
    localparam int BPC = 11;
`else
    localparam int BPC = 10;
`endif
    localparam int FRAME_CLKS = 10 * BPC * DIV;

    logic        clock;
    logic        reset;
    logic [23:0] data_time;
    logic        send;
    logic        auto_en;
    logic        txd;
    logic        busy;
    logic        frame_done;

    time_uart_tx #(
        .CLK_HZ(1000),
        .BAUD  (100)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .data_time (data_time),
        .send      (send),
        .auto_en   (auto_en),
        .txd       (txd),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         checkCount = 0;
    int         passCount  = 0;
    int         cyc        = 0;
    int         doneCount  = 0;
    int         epoch      = 0;
    logic [7:0] expQ[$];

    // Time order of '1' (8'h31): start, LSB-first data, parity (if enabled), stop.
    int firstBits[11] = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1};

    always @(posedge clock) cyc = cyc + 1;
    always @(negedge clock) if (frame_done === 1'b1) doneCount = doneCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    endtask

    task automatic pushString(input string s);
        for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
    endtask

    // Drives one send pulse; returns at the negedge after the edge that sampled it.
    task automatic applyStimulus(input logic [23:0] t, input string s);
        data_time = t;
        send      = 1'b1;
        pushString(s);
        @(negedge clock);
        send      = 1'b0;
    endtask

    task automatic waitFrameDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < FRAME_CLKS + 200; i++) begin
            @(negedge clock);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    // Monitor: UART receiver sampling bit centres, popping the scoreboard per character.
    logic [7:0] rxByte;
    logic       rxStart, rxStop, rxPar;
    logic [7:0] rxExp;
    int         rxEpoch;
    always begin
        @(negedge clock);
        if (reset === 1'b1 && txd === 1'b0) begin
            rxEpoch = epoch;
            rxPar   = 1'b0;
            repeat (DIV / 2) @(negedge clock);
            rxStart = txd;
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clock);
                rxByte[i] = txd;
            end
`ifdef TIME_TX_PARITY_EN
            repeat (DIV) @(negedge clock);
            rxPar = txd;
`endif
            repeat (DIV) @(negedge clock);
            rxStop = txd;
            if (rxEpoch == epoch) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected char: got 'h%0h, expected none", rxByte);
                end else begin
                    rxExp = expQ.pop_front();
                    checkOutput("rx char", 32'(rxByte), 32'(rxExp));
                    checkOutput("rx start/stop", 32'({rxStart, rxStop}), 32'b01);
`ifdef TIME_TX_PARITY_EN
                    checkOutput("rx parity", 32'(rxPar), 32'(^rxExp));
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int d0;
        int bad;
        reset     = 1'b0;
        data_time = 24'h000000;
        send      = 1'b0;
        auto_en   = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset txd", 32'(txd), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        $display("[TB] test 1: send 12:34:56");
        data_time = 24'h123456;
        @(negedge clock);
        applyStimulus(24'h123456, "12:34:56\r\n");
        t0 = cyc;
        checkOutput("start busy", 32'(busy), 32'd1);
        for (int b = 0; b < BPC; b++) begin
            bad = 0;
            for (int c = 0; c < DIV; c++) begin
                if (b != 0 || c != 0) @(negedge clock);
                if (txd !== firstBits[b][0]) bad++;
            end
            checkOutput($sformatf("char0 bit%0d wrong clocks", b), 32'(bad), 32'd0);
        end
        waitFrameDone("t1 frame_done");
        checkOutput("t1 frame length", 32'(cyc - t0), 32'(FRAME_CLKS));
        checkOutput("t1 busy in done", 32'(busy), 32'd0);
        @(negedge clock);
        checkOutput("t1 idle txd", 32'(txd), 32'd1);
        checkOutput("t1 idle busy", 32'(busy), 32'd0);

        $display("[TB] test 2: auto trigger on time change");
        data_time = 24'h235959;
        repeat (5) @(negedge clock);
        auto_en = 1'b1;
        d0 = doneCount;
        repeat (20) @(negedge clock);
        checkOutput("t2 no frame without change", 32'(busy), 32'd0);
        data_time = 24'h000000;
        pushString("00:00:00\r\n");
        waitFrameDone("t2 frame_done");
        repeat (300) @(negedge clock);
        checkOutput("t2 frame count", 32'(doneCount - d0), 32'd1);
        auto_en = 1'b0;

        $display("[TB] test 3: requests merge while busy");
        d0 = doneCount;
        applyStimulus(24'h024513, "02:45:13\r\n");
        repeat (200) @(negedge clock);
        applyStimulus(24'h024513, "02:45:13\r\n");
        repeat (100) @(negedge clock);
        applyStimulus(24'h024513, "");
        repeat (100) @(negedge clock);
        applyStimulus(24'h024513, "");
        waitFrameDone("t3 first frame_done");
        checkOutput("t3 busy in done", 32'(busy), 32'd0);
        @(negedge clock);
        checkOutput("t3 back-to-back busy", 32'(busy), 32'd1);
        checkOutput("t3 back-to-back start", 32'(txd), 32'd0);
        waitFrameDone("t3 second frame_done");
        repeat (FRAME_CLKS + 200) @(negedge clock);
        checkOutput("t3 frame count", 32'(doneCount - d0), 32'd2);
        checkOutput("t3 idle busy", 32'(busy), 32'd0);

        $display("[TB] test 4: invalid digit and snapshot hold");
        applyStimulus(24'h1A0000, "1?:00:00\r\n");
        repeat (300) @(negedge clock);
        data_time = 24'h999999;
        waitFrameDone("t4 frame_done");
        repeat (20) @(negedge clock);

        $display("[TB] test 5: reset mid-frame");
        applyStimulus(24'h123456, "12:3");
        repeat (4 * BPC * DIV + 4 * DIV + 5) @(negedge clock);
        checkOutput("t5 txd before reset", 32'(txd), 32'd0);
        epoch = epoch + 1;
        d0    = doneCount;
        reset = 1'b0;
        #1;
        checkOutput("t5 txd in reset", 32'(txd), 32'd1);
        checkOutput("t5 busy in reset", 32'(busy), 32'd0);
        repeat (150) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("t5 no frame_done", 32'(doneCount - d0), 32'd0);
        checkOutput("t5 idle after release", 32'(busy), 32'd0);
        applyStimulus(24'h123456, "12:34:56\r\n");
        t0 = cyc;
        waitFrameDone("t5 frame_done");
        checkOutput("t5 frame length", 32'(cyc - t0), 32'(FRAME_CLKS));

        repeat (50) @(negedge clock);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
